stack_op_sequencer: RTL

- Sequencing controller for the 8-bit push-down stack calculator.
- Turns raw button levels plus the 2-bit mode switches into multi-cycle operation sequences against a single-port synchronous stack RAM (1-cycle read latency).
- Owns the stack pointer, the entry count, the display address register and the display value register. Rejects illegal operations.
- Sits between the board switch/button inputs and the stack RAM / 7-segment display driver.

---
 rtl/stack_op_sequencer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/stack_op_sequencer.sv
`default_nettype none
// ============================================================================
// stack_op_sequencer : button-driven op sequencer for the 8-bit stack calculator
// Revision: 1.0 - initial release
// ============================================================================
module stack_op_sequencer #(
  parameter int DW    = 8,
  parameter int AW    = 7,
  parameter int DEPTH = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    ctrl,
  input  logic          btnl,
  input  logic          btnr,
  input  logic [DW-1:0] numeral,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] dvr,
  output logic [AW-1:0] dar,
  output logic          empty,
  output logic          full,
  output logic          busy,
  output logic          err
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_A   = 3'd1,
    S_RD_B   = 3'd2,
    S_CAP_B  = 3'd3,
    S_WR     = 3'd4,
    S_DISP   = 3'd5,
    S_DISP_W = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } op_t;

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  logic [AW-1:0]   sp_q, sp_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   dar_q, dar_d;
  logic [DW-1:0]   dvr_q, dvr_d;
  logic [DW-1:0]   opa_q, opa_d;
  logic [DW-1:0]   opb_q, opb_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            err_q, err_d;
  logic            btnl_q, btnl_d;
  logic            btnr_q, btnr_d;

  logic            rise_l, rise_r;

  assign rise_l = btnl & ~btnl_q;
  assign rise_r = btnr & ~btnr_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sp_d     = sp_q;
    count_d  = count_q;
    dar_d    = dar_q;
    dvr_d    = dvr_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    err_d    = 1'b0;
    btnl_d   = btnl;
    btnr_d   = btnr;
    mem_addr = addr_q;
    mem_we   = 1'b0;

    // opa holds the push operand or the top entry, opb the second entry
    case (op_q)
      OP_ADD:  mem_wdata = opb_q + opa_q;
      OP_SUB:  mem_wdata = opb_q - opa_q;
      default: mem_wdata = opa_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (rise_l) begin
          case (ctrl)
            2'b00: begin
              if (count_q == CW'(0)) begin
                err_d = 1'b1;
              end else begin
                sp_d    = sp_q + AW'(1);
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                  dar_d = '0;
                  dvr_d = '0;
                end else begin
                  dar_d   = sp_q + AW'(2);
                  state_d = S_DISP;
                end
              end
            end
            2'b01: begin
              if (count_q < CW'(2)) begin
                err_d = 1'b1;
              end else begin
                op_d    = OP_SUB;
                state_d = S_RD_A;
              end
            end
            2'b10: begin
              sp_d    = AW'(DEPTH - 1);
              count_d = '0;
              dar_d   = '0;
              dvr_d   = '0;
            end
            default: begin
              dar_d   = dar_q - AW'(1);
              state_d = S_DISP;
            end
          endcase
        end else if (rise_r) begin
          case (ctrl)
            2'b00: begin
              if (count_q == CW'(DEPTH)) begin
                err_d = 1'b1;
              end else begin
                opa_d   = numeral;
                op_d    = OP_PUSH;
                state_d = S_WR;
              end
            end
            2'b01: begin
              if (count_q < CW'(2)) begin
                err_d = 1'b1;
              end else begin
                op_d    = OP_ADD;
                state_d = S_RD_A;
              end
            end
            2'b10: begin
              if (count_q != CW'(0)) begin
                dar_d = sp_q + AW'(1);
              end
              state_d = S_DISP;
            end
            default: begin
              dar_d   = dar_q + AW'(1);
              state_d = S_DISP;
            end
          endcase
        end
      end
      S_RD_A: begin
        mem_addr = sp_q + AW'(1);
        state_d  = S_RD_B;
      end
      S_RD_B: begin
        mem_addr = sp_q + AW'(2);
        opa_d    = mem_rdata;
        state_d  = S_CAP_B;
      end
      S_CAP_B: begin
        opb_d   = mem_rdata;
        state_d = S_WR;
      end
      S_WR: begin
        mem_we = 1'b1;
        if (op_q == OP_PUSH) begin
          mem_addr = sp_q;
          sp_d     = sp_q - AW'(1);
          count_d  = count_q + CW'(1);
          dar_d    = sp_q;
        end else begin
          // result overwrites the second entry, which becomes the new top
          mem_addr = sp_q + AW'(2);
          sp_d     = sp_q + AW'(1);
          count_d  = count_q - CW'(1);
          dar_d    = sp_q + AW'(2);
        end
        state_d = S_DISP;
      end
      S_DISP: begin
        mem_addr = dar_q;
        state_d  = S_DISP_W;
      end
      S_DISP_W: begin
        dvr_d   = mem_rdata;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    addr_d = mem_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_PUSH;
      sp_q    <= AW'(DEPTH - 1);
      count_q <= '0;
      dar_q   <= '0;
      dvr_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      btnl_q  <= 1'b0;
      btnr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sp_q    <= sp_d;
      count_q <= count_d;
      dar_q   <= dar_d;
      dvr_q   <= dvr_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      btnl_q  <= btnl_d;
      btnr_q  <= btnr_d;
    end
  end

  assign dvr   = dvr_q;
  assign dar   = dar_q;
  assign empty = (count_q == CW'(0));
  assign full  = (count_q == CW'(DEPTH));
  assign busy  = (state_q != S_IDLE);
  assign err   = err_q;

endmodule
`default_nettype wire
